// File: rtl/b_engine.sv
// K-means assignment/accumulation engine: nearest enabled mean per pixel (L1),
// per-cluster RGB sums and pixel counts, frozen totals with done at end of image.
module b_engine #(
  parameter int T  = 16,
  parameter int CW = 16,
  parameter int AW = 8 + CW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic                endOfImage,
  input  logic [23:0]         pixelIn,
  input  logic [24*T-1:0]     meanIn,
  input  logic [T-1:0]        enabled,
  output logic [3*AW*T-1:0]   accumolator,
  output logic [CW*T-1:0]     counters,
  output logic                done
);

  // state   | meaning
  // S_ACCUM | accepting pixels into the running totals
  // S_DRAIN | end of image seen, last captured pixel still being added
  // S_DONE  | totals final and frozen; next valid pixel starts a new image
  typedef enum logic [1:0] {S_ACCUM, S_DRAIN, S_DONE} state_t;

  localparam int IW = (T > 1) ? $clog2(T) : 1;

  state_t          r_state;
  logic            r_done;
  logic            r_hit;
  logic            r_first;
  logic [23:0]     r_pix;
  logic [IW-1:0]   r_idx;
  logic [AW-1:0]   r_rsum [T];
  logic [AW-1:0]   r_gsum [T];
  logic [AW-1:0]   r_bsum [T];
  logic [CW-1:0]   r_cnt  [T];

  logic            w_any;
  logic [9:0]      w_best;
  logic [IW-1:0]   w_idx;
  logic            w_accept;
  logic            w_restart;

  function automatic logic [9:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? {2'b00, a - b} : {2'b00, b - a};
  endfunction

  function automatic logic [9:0] l1_dist(input logic [23:0] p, input logic [23:0] m);
    return abs_diff(p[23:16], m[23:16]) + abs_diff(p[15:8], m[15:8]) + abs_diff(p[7:0], m[7:0]);
  endfunction

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    w_any  = 1'b0;
    w_best = '1;
    w_idx  = '0;
    for (int i = 0; i < T; i++) begin
      if (enabled[i] && (!w_any || l1_dist(pixelIn, meanIn[24*i +: 24]) < w_best)) begin
        w_any  = 1'b1;
        w_best = l1_dist(pixelIn, meanIn[24*i +: 24]);
        w_idx  = IW'(i);
      end
    end
  end

  assign w_accept  = valid && (r_state == S_ACCUM || r_state == S_DONE);
  assign w_restart = valid && (r_state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_ACCUM;
      r_done  <= 1'b0;
      r_hit   <= 1'b0;
      r_first <= 1'b0;
      r_pix   <= '0;
      r_idx   <= '0;
    end else begin
      r_hit   <= w_accept && w_any;
      r_first <= w_restart;
      if (w_accept) begin
        r_pix <= pixelIn;
        r_idx <= w_idx;
      end
      case (r_state)
        S_ACCUM: if (endOfImage) r_state <= S_DRAIN;
        S_DRAIN: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: if (valid) begin
          r_done  <= 1'b0;
          r_state <= endOfImage ? S_DRAIN : S_ACCUM;
        end
        default: r_state <= S_ACCUM;
      endcase
    end
  end

  // A restart pixel wipes the previous image even if it hits no cluster.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < T; i++) begin
        r_rsum[i] <= '0;
        r_gsum[i] <= '0;
        r_bsum[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else if (r_hit || r_first) begin
      for (int i = 0; i < T; i++) begin
        if (r_hit && r_idx == IW'(i)) begin
          if (r_first) begin
            r_rsum[i] <= AW'(r_pix[23:16]);
            r_gsum[i] <= AW'(r_pix[15:8]);
            r_bsum[i] <= AW'(r_pix[7:0]);
            r_cnt[i]  <= CW'(1);
          end else begin
            r_rsum[i] <= r_rsum[i] + AW'(r_pix[23:16]);
            r_gsum[i] <= r_gsum[i] + AW'(r_pix[15:8]);
            r_bsum[i] <= r_bsum[i] + AW'(r_pix[7:0]);
            r_cnt[i]  <= r_cnt[i] + CW'(1);
          end
        end else if (r_first) begin
          r_rsum[i] <= '0;
          r_gsum[i] <= '0;
          r_bsum[i] <= '0;
          r_cnt[i]  <= '0;
        end
      end
    end
  end

  for (genvar g = 0; g < T; g++) begin : g_pack
    assign accumolator[3*AW*g +: 3*AW] = {r_rsum[g], r_gsum[g], r_bsum[g]};
    assign counters[CW*g +: CW]        = r_cnt[g];
  end

  assign done = r_done;

endmodule

// File: tb/tb_b_engine.sv
// Scoreboard bench for b_engine: a spec-level model predicts per-image totals,
// a monitor compares them when done rises and while the totals are held.
module tb_b_engine;
  localparam int T  = 16;
  localparam int CW = 16;
  localparam int AW = 24;
  localparam int AV = 3*AW*T;
  localparam int CV = CW*T;

  logic           clk = 1'b0;
  logic           reset;
  logic           valid;
  logic           endOfImage;
  logic [23:0]    pixelIn;
  logic [24*T-1:0] meanIn;
  logic [T-1:0]   enabled;
  logic [AV-1:0]  accumolator;
  logic [CV-1:0]  counters;
  logic           done;

  b_engine #(.T(T), .CW(CW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .valid(valid), .endOfImage(endOfImage),
    .pixelIn(pixelIn), .meanIn(meanIn), .enabled(enabled),
    .accumolator(accumolator), .counters(counters), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AV-1:0] acc;
    logic [CV-1:0] cnt;
    int            done_cyc;
  } exp_t;
  exp_t sb_q[$];

  logic [23:0] means [T];
  int m_r[T], m_g[T], m_b[T], m_c[T];
  bit closed;
  int eoi_edge;

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int nearest(input logic [23:0] p, input logic [T-1:0] en);
    int best = -1;
    int bd = 0;
    for (int i = 0; i < T; i++) begin
      if (en[i]) begin
        logic [23:0] m;
        int d;
        m = means[i];
        d = absd(p[23:16], m[23:16]) + absd(p[15:8], m[15:8]) + absd(p[7:0], m[7:0]);
        if (best < 0 || d < bd) begin
          best = i;
          bd = d;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [24*T-1:0] pack_means();
    logic [24*T-1:0] v;
    for (int i = 0; i < T; i++) v[24*i +: 24] = means[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < T; i++) begin
      m_r[i] = 0; m_g[i] = 0; m_b[i] = 0; m_c[i] = 0;
    end
  endtask

  task automatic build(output logic [AV-1:0] acc, output logic [CV-1:0] cnt);
    acc = '0;
    cnt = '0;
    for (int i = 0; i < T; i++) begin
      acc[3*AW*i +: 3*AW] = {AW'(m_r[i]), AW'(m_g[i]), AW'(m_b[i])};
      cnt[CW*i +: CW] = CW'(m_c[i]);
    end
  endtask

  task automatic chk_pk(input string nm, input logic [AV-1:0] act, input logic [AV-1:0] exp, input int w);
    checks++;
    if (act !== exp) begin
      logic [AV-1:0] mask, a, b, fa, fb;
      int first = -1;
      int ndiff = 0;
      mask = ~({AV{1'b1}} << w);
      fa = '0;
      fb = '0;
      for (int i = 0; i < T; i++) begin
        a = (act >> (w*i)) & mask;
        b = (exp >> (w*i)) & mask;
        if (a !== b) begin
          ndiff++;
          if (first < 0) begin
            first = i; fa = a; fb = b;
          end
        end
      end
      errors++;
      $display("FAIL %s: cluster %0d got %0h want %0h (%0d clusters differ)", nm, first, fa, fb, ndiff);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic spot(input string nm);
    logic [AV-1:0] a;
    logic [CV-1:0] c;
    build(a, c);
    chk_pk({nm, "_acc"}, accumolator, a, AW);
    chk_pk({nm, "_cnt"}, AV'(counters), AV'(c), CW);
  endtask

  task automatic send(input logic [23:0] p, input logic v, input logic eoi, input logic [T-1:0] en);
    int edge_n, idx;
    exp_t e;
    @(negedge clk);
    valid = v; endOfImage = eoi; pixelIn = p; enabled = en; meanIn = pack_means();
    edge_n = cyc + 1;
    if (v && closed && edge_n > eoi_edge + 1) begin
      model_clear();
      closed = 1'b0;
    end
    if (v && !closed) begin
      idx = nearest(p, en);
      if (idx >= 0) begin
        m_r[idx] += int'(p[23:16]);
        m_g[idx] += int'(p[15:8]);
        m_b[idx] += int'(p[7:0]);
        m_c[idx] += 1;
      end
    end
    if (eoi && !closed) begin
      build(e.acc, e.cnt);
      e.done_cyc = edge_n + 1;
      sb_q.push_back(e);
      closed = 1'b1;
      eoi_edge = edge_n;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) send(24'h0, 1'b0, 1'b0, enabled);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 12 && sb_q.size() != 0; k++) idle(1);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL done_timeout: pending images %0d want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic chk_zero(input string nm);
    chk_pk({nm, "_acc"}, accumolator, '0, AW);
    chk_pk({nm, "_cnt"}, AV'(counters), '0, CW);
    chk_bit({nm, "_done"}, done, 1'b0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    valid = 1'b0; endOfImage = 1'b0;
    #1 chk_zero("mid_reset");
    model_clear();
    closed = 1'b0;
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compare totals on the rising edge of done, then check they stay frozen.
  bit prev_done = 1'b0;
  bit hold = 1'b0;
  exp_t last;
  always @(negedge clk) begin
    if (reset) begin
      prev_done = 1'b0;
      hold = 1'b0;
    end else begin
      if (done && !prev_done) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: done rose at cycle %0d with no image pending", cyc);
        end else begin
          last = sb_q.pop_front();
          checks--;
          chk_bit("done_timing", cyc == last.done_cyc, 1'b1);
          if (cyc != last.done_cyc) $display("  done cycle %0d vs %0d", cyc, last.done_cyc);
          chk_pk("final_acc", accumolator, last.acc, AW);
          chk_pk("final_cnt", AV'(counters), AV'(last.cnt), CW);
          hold = 1'b1;
        end
      end else if (done && hold) begin
        chk_pk("hold_acc", accumolator, last.acc, AW);
      end
      prev_done = done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; valid = 1'b0; endOfImage = 1'b0; pixelIn = '0; enabled = '1;
    for (int i = 0; i < T; i++) means[i] = (i == 0) ? 24'hFFFFFF : {3{8'((15 - i) * 16)}};
    meanIn = pack_means();
    model_clear();
    closed = 1'b0;
    eoi_edge = -10;
    #12 chk_zero("in_reset");
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    chk_zero("idle");

    // Single pixel, latency, end of image without valid
    send(24'h101010, 1'b1, 1'b0, '1);
    idle(1);
    chk_pk("latency_cnt", AV'(counters), '0, CW);
    idle(1);
    spot("single");
    send(24'h0, 1'b0, 1'b1, '1);
    wait_done();
    idle(2);

    // Restart, then ties
    send(24'h000000, 1'b1, 1'b0, '1);
    idle(1);
    chk_bit("done_fall", done, 1'b0);
    idle(1);
    spot("restart");
    send(24'h080808, 1'b1, 1'b0, '1);
    send(24'hF0F0F0, 1'b1, 1'b0, '1);
    idle(2);
    spot("tie");
    send(24'h101010, 1'b1, 1'b1, '1);
    wait_done();
    idle(2);

    // Disabled clusters; a valid pixel during drain must be ignored
    send(24'hFFFFFF, 1'b1, 1'b0, 16'hFFFE);
    send(24'hFFFFFF, 1'b1, 1'b0, 16'h0000);
    send(24'h0, 1'b0, 1'b1, '1);
    send(24'hFFFFFF, 1'b1, 1'b0, '1);
    wait_done();
    idle(2);

    // Reset in the middle of an image, then a fresh image from reset
    send(24'h202020, 1'b1, 1'b0, '1);
    send(24'h303030, 1'b1, 1'b0, '1);
    mid_reset();
    send(24'h404040, 1'b1, 1'b0, '1);
    send(24'hC0C0C0, 1'b1, 1'b1, '1);
    wait_done();
    idle(2);

    // Long back-to-back stream
    for (int k = 0; k < 2800; k++) send(24'hFFFFFF, 1'b1, k == 2799, '1);
    wait_done();
    idle(2);

    // Randomized images with random means and enables
    for (int im = 0; im < 6; im++) begin
      int npix, late;
      npix = $urandom_range(20, 60);
      late = $urandom_range(0, 1);
      for (int i = 0; i < T; i++) means[i] = 24'($urandom());
      for (int k = 0; k < npix; k++) begin
        logic [T-1:0] en;
        int r;
        logic v;
        r = $urandom_range(0, 9);
        en = (r < 7) ? '1 : (r < 9) ? T'($urandom()) : '0;
        v = (k == 0) || ($urandom_range(0, 3) != 0);
        send(24'($urandom()), v, (k == npix - 1) && (late == 0), en);
      end
      if (late != 0) begin
        idle($urandom_range(0, 2));
        send(24'h0, 1'b0, 1'b1, '1);
      end
      wait_done();
      idle(3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
